// File: rtl/dvp_capture_pkg.sv
// dvp_capture_pkg: shared modes, FSM encoding, error bit indices and counter widths for DVP capture
package dvp_capture_pkg;
  localparam logic [1:0] MODE_RGB565_HI = 2'd0;
  localparam logic [1:0] MODE_RAW8      = 2'd1;
  localparam logic [1:0] MODE_YUV_Y     = 2'd2;
  localparam logic [1:0] MODE_RGB565_LO = 2'd3;
  typedef enum logic [2:0] {ST_UNSYNC, ST_VBLANK, ST_LINE, ST_HBLANK, ST_SKIP} state_t;
  localparam int ERR_LEN   = 0;
  localparam int ERR_LINES = 1;
  localparam int ERR_ODD   = 2;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1) + 1;
  endfunction
endpackage

// File: rtl/dvp_byte_packer.sv
// dvp_byte_packer: pairs sensor bytes per mode and maps them to a registered, truncated RGB pixel
module dvp_byte_packer
  import dvp_capture_pkg::*;
#(
  parameter int RED_DEPTH   = 5,
  parameter int GREEN_DEPTH = 6,
  parameter int BLUE_DEPTH  = 5
) (
  input  logic                   i_ov5640_pclk,
  input  logic                   i_arst_pclk_x1,
  input  logic [7:0]             d,
  input  logic [1:0]             mode,
  input  logic                   byte_en,
  input  logic                   line_start,
  output logic                   stb,
  output logic                   phase,
  output logic [RED_DEPTH-1:0]   r,
  output logic [GREEN_DEPTH-1:0] g,
  output logic [BLUE_DEPTH-1:0]  b
);
  logic ph, two, emit;
  logic [7:0] hi, rv, gv, bv;
  logic [15:0] w;
  always_comb begin
    ph = line_start ? 1'b0 : phase;
    two = mode != MODE_RAW8;
    emit = byte_en & (~two | ph);
    w = (mode == MODE_RGB565_LO) ? {d, hi} : {hi, d};
    rv = (mode == MODE_RAW8) ? d : (mode == MODE_YUV_Y) ? hi : {w[15:11], w[15:13]};
    gv = (mode == MODE_RAW8) ? d : (mode == MODE_YUV_Y) ? hi : {w[10:5], w[10:9]};
    bv = (mode == MODE_RAW8) ? d : (mode == MODE_YUV_Y) ? hi : {w[4:0], w[4:2]};
  end
  always_ff @(posedge i_ov5640_pclk or posedge i_arst_pclk_x1)
    if (i_arst_pclk_x1) begin
      stb <= 1'b0;
      phase <= 1'b0;
      hi <= '0;
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      stb <= emit;
      if (line_start | byte_en) phase <= byte_en & two & ~ph;
      if (byte_en & ~ph) hi <= d;
      if (emit) begin
        r <= RED_DEPTH'(rv >> (8 - RED_DEPTH));
        g <= GREEN_DEPTH'(gv >> (8 - GREEN_DEPTH));
        b <= BLUE_DEPTH'(bv >> (8 - BLUE_DEPTH));
      end
    end
endmodule

// File: rtl/dvp_capture_param.sv
// dvp_capture_param: OV5640 DVP capture front-end with frame sync, byte packing,
// frame/line markers and line-length / line-count checking.
module dvp_capture_param
  import dvp_capture_pkg::*;
#(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int RED_DEPTH   = 5,
  parameter int GREEN_DEPTH = 6,
  parameter int BLUE_DEPTH  = 5,
  parameter bit VS_ACT_HIGH = 1'b1,
  parameter int FCNT_W      = 16
) (
  input  logic                          i_ov5640_pclk,
  input  logic                          i_arst_pclk_x1,
  input  logic                          i_ov5640_vsync,
  input  logic                          i_ov5640_href,
  input  logic [7:0]                    i_ov5640_d,
  input  logic                          i_enable,
  input  logic [1:0]                    i_mode,
  input  logic                          i_err_clr,
  output logic                          o_synced,
  output logic                          o_valid,
  output logic                          o_sof,
  output logic                          o_eol,
  output logic                          o_eof,
  output logic [RED_DEPTH-1:0]          o_r,
  output logic [GREEN_DEPTH-1:0]        o_g,
  output logic [BLUE_DEPTH-1:0]         o_b,
  output logic [cnt_w(H_ACTIVE)-1:0]    o_line_len,
  output logic [cnt_w(V_ACTIVE)-1:0]    o_line_cnt,
  output logic [FCNT_W-1:0]             o_frame_cnt,
  output logic [2:0]                    o_err
);
  localparam int LW = cnt_w(H_ACTIVE);
  localparam int CW = cnt_w(V_ACTIVE);
  state_t state, nxt;
  logic va_q, va_qq, hr_q, hr_qq, en_q, clr_q, en_lat, sof_pend, eol_d;
  logic [7:0] d_q;
  logic [1:0] mode_q, mode_lat;
  logic vs_rise, vs_fall, hr_rise, hr_fall, line_end, frame_end, byte_en, stb, phase;
  logic [RED_DEPTH-1:0] pr;
  logic [GREEN_DEPTH-1:0] pg;
  logic [BLUE_DEPTH-1:0] pb;
  logic [LW-1:0] px_cnt, px_len;
  logic [CW-1:0] ln_cnt;
  logic [2:0] err_set;
  dvp_byte_packer #(.RED_DEPTH(RED_DEPTH), .GREEN_DEPTH(GREEN_DEPTH), .BLUE_DEPTH(BLUE_DEPTH)) u_packer (
    .i_ov5640_pclk (i_ov5640_pclk),
    .i_arst_pclk_x1(i_arst_pclk_x1),
    .d             (d_q),
    .mode          (mode_lat),
    .byte_en       (byte_en),
    .line_start    (hr_rise),
    .stb           (stb),
    .phase         (phase),
    .r             (pr),
    .g             (pg),
    .b             (pb)
  );
  // The first byte of a line arrives while the FSM still sits in a blank state
  always_comb begin
    vs_rise = va_q & ~va_qq;
    vs_fall = ~va_q & va_qq;
    hr_rise = hr_q & ~hr_qq;
    hr_fall = ~hr_q & hr_qq;
    line_end = (state == ST_LINE) & hr_fall & ~vs_rise;
    frame_end = ((state == ST_LINE) | (state == ST_HBLANK)) & vs_rise;
    byte_en = hr_q & ((state == ST_LINE) | (hr_rise & ((state == ST_HBLANK) | ((state == ST_VBLANK) & en_lat))));
    px_len = (&px_cnt) ? px_cnt : px_cnt + LW'(stb);
    err_set = '0;
    err_set[ERR_LEN] = line_end & (px_len != LW'(H_ACTIVE));
    err_set[ERR_LINES] = frame_end & (ln_cnt != CW'(V_ACTIVE));
    err_set[ERR_ODD] = line_end & phase;
    nxt = state;
    case (state)
      ST_UNSYNC: nxt = vs_fall ? ST_VBLANK : ST_UNSYNC;
      ST_VBLANK: nxt = hr_rise ? (en_lat ? ST_LINE : ST_SKIP) : ST_VBLANK;
      ST_LINE:   nxt = vs_rise ? ST_VBLANK : hr_fall ? ST_HBLANK : ST_LINE;
      ST_HBLANK: nxt = vs_rise ? ST_VBLANK : hr_rise ? ST_LINE : ST_HBLANK;
      ST_SKIP:   nxt = vs_rise ? ST_VBLANK : ST_SKIP;
      default:   nxt = ST_UNSYNC;
    endcase
  end
  always_ff @(posedge i_ov5640_pclk or posedge i_arst_pclk_x1)
    if (i_arst_pclk_x1) begin
      state <= ST_UNSYNC;
      {va_q, va_qq, hr_q, hr_qq, en_q, clr_q, en_lat, sof_pend, eol_d} <= '0;
      d_q <= '0;
      mode_q <= '0;
      mode_lat <= '0;
      px_cnt <= '0;
      ln_cnt <= '0;
      {o_synced, o_valid, o_sof, o_eol, o_eof} <= '0;
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
      o_line_len <= '0;
      o_line_cnt <= '0;
      o_frame_cnt <= '0;
      o_err <= '0;
    end else begin
      state <= nxt;
      va_q <= VS_ACT_HIGH ? i_ov5640_vsync : ~i_ov5640_vsync;
      va_qq <= va_q;
      hr_q <= i_ov5640_href;
      hr_qq <= hr_q;
      d_q <= i_ov5640_d;
      en_q <= i_enable;
      mode_q <= i_mode;
      clr_q <= i_err_clr;
      px_cnt <= hr_rise ? '0 : px_len;
      if (line_end) begin
        o_line_len <= px_len;
        ln_cnt <= (&ln_cnt) ? ln_cnt : ln_cnt + CW'(1);
      end
      if (stb) sof_pend <= 1'b0;
      if (vs_fall) begin
        en_lat <= en_q;
        mode_lat <= mode_q;
        sof_pend <= 1'b1;
        ln_cnt <= '0;
      end
      if ((state == ST_UNSYNC) & vs_fall) o_synced <= 1'b1;
      if (frame_end) begin
        o_line_cnt <= ln_cnt;
        o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
      end
      o_eof <= frame_end;
      eol_d <= line_end;
      o_eol <= eol_d;
      o_err <= (o_err & ~{3{clr_q}}) | err_set;
      o_valid <= stb;
      o_sof <= stb & sof_pend;
      if (stb) begin
        o_r <= pr;
        o_g <= pg;
        o_b <= pb;
      end
    end
endmodule

// File: tb/tb_dvp_capture_param.sv
// tb_dvp_capture_param: directed frame scenarios for dvp_capture_param in a 4x3 geometry
module tb_dvp_capture_param;
  logic clk = 1'b0, rst = 1'b1, vs = 1'b0, hr = 1'b0, en = 1'b0, clr = 1'b0;
  logic [7:0] d = '0;
  logic [1:0] mode = '0;
  logic synced, valid, sof, eol, eof;
  logic [4:0] r, b, exp_r, exp_b;
  logic [5:0] g, exp_g;
  logic [3:0] line_len;
  logic [2:0] line_cnt, err;
  logic [15:0] fcnt;
  int cyc, n_pix, n_sof, sof_idx, n_eol, n_eol_v, n_eof, n_badc, t_first, t_b1;
  int p0, s0, e0, f0, c0, v0, t0;
  int n_tests, n_fail;

  dvp_capture_param #(.H_ACTIVE(4), .V_ACTIVE(3)) dut (
    .i_ov5640_pclk (clk),
    .i_arst_pclk_x1(rst),
    .i_ov5640_vsync(vs),
    .i_ov5640_href (hr),
    .i_ov5640_d    (d),
    .i_enable      (en),
    .i_mode        (mode),
    .i_err_clr     (clr),
    .o_synced      (synced),
    .o_valid       (valid),
    .o_sof         (sof),
    .o_eol         (eol),
    .o_eof         (eof),
    .o_r           (r),
    .o_g           (g),
    .o_b           (b),
    .o_line_len    (line_len),
    .o_line_cnt    (line_cnt),
    .o_frame_cnt   (fcnt),
    .o_err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (valid) begin
      if (sof) begin
        sof_idx = n_pix;
        t_first = cyc;
        n_sof++;
      end
      if (r !== exp_r || g !== exp_g || b !== exp_b) n_badc++;
      n_pix++;
    end
    if (eol) begin
      n_eol++;
      if (valid) n_eol_v++;
    end
    if (eof) n_eof++;
  end

  task automatic drive(input logic v, input logic h, input logic [7:0] x);
    @(negedge clk);
    vs = v;
    hr = h;
    d = x;
  endtask

  task automatic vpulse;
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic ln(input int nb, input logic [7:0] b0, input logic [7:0] b1);
    for (int j = 0; j < nb; j++) begin
      drive(1'b0, 1'b1, j[0] ? b1 : b0);
      if (j == 1) t_b1 = cyc;
    end
    repeat (4) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic setc(input logic [4:0] rr, input logic [5:0] gg, input logic [4:0] bb);
    exp_r = rr;
    exp_g = gg;
    exp_b = bb;
  endtask

  task automatic snap;
    p0 = n_pix; s0 = n_sof; e0 = n_eol; f0 = n_eof; c0 = n_badc; v0 = n_eol_v;
  endtask

  task automatic pulse_clr;
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if ({valid, sof, eol, eof} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {valid, sof, eol, eof}); end
    n_tests++; if (synced !== 1'b0) begin n_fail++; $display("FAIL rst_synced: got %b want 0", synced); end
    n_tests++; if ({fcnt, err} !== 19'd0) begin n_fail++; $display("FAIL rst_cnt_err: got fcnt=%0d err=%b want 0", fcnt, err); end
    n_tests++; if ({line_len, line_cnt} !== 7'd0) begin n_fail++; $display("FAIL rst_geom: got len=%0d lines=%0d want 0", line_len, line_cnt); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rgb565;
    en = 1'b1;
    mode = 2'd0;
    vpulse;
    n_tests++; if (synced !== 1'b1) begin n_fail++; $display("FAIL sync: got %b want 1", synced); end
    setc(5'h1f, 6'h00, 5'h00);
    snap;
    ln(8, 8'hf8, 8'h00);
    t0 = t_b1;
    ln(8, 8'hf8, 8'h00);
    ln(8, 8'hf8, 8'h00);
    vpulse;
    n_tests++; if (n_pix - p0 !== 12) begin n_fail++; $display("FAIL rgb_pix: got %0d want 12", n_pix - p0); end
    n_tests++; if (n_badc - c0 !== 0) begin n_fail++; $display("FAIL rgb_colour: got %0d bad want 0", n_badc - c0); end
    n_tests++; if (n_sof - s0 !== 1 || sof_idx !== p0) begin n_fail++; $display("FAIL rgb_sof: got n=%0d idx=%0d want 1 at %0d", n_sof - s0, sof_idx, p0); end
    n_tests++; if (n_eol - e0 !== 3) begin n_fail++; $display("FAIL rgb_eol: got %0d want 3", n_eol - e0); end
    n_tests++; if (n_eol_v - v0 !== 0) begin n_fail++; $display("FAIL rgb_eol_valid: got %0d want 0", n_eol_v - v0); end
    n_tests++; if (n_eof - f0 !== 1) begin n_fail++; $display("FAIL rgb_eof: got %0d want 1", n_eof - f0); end
    n_tests++; if (t_first - t0 !== 3) begin n_fail++; $display("FAIL rgb_latency: got %0d want 3", t_first - t0); end
    n_tests++; if (err !== 3'b000) begin n_fail++; $display("FAIL rgb_err: got %b want 000", err); end
    n_tests++; if (fcnt !== 16'd1) begin n_fail++; $display("FAIL rgb_fcnt: got %0d want 1", fcnt); end
    n_tests++; if (line_len !== 4'd4 || line_cnt !== 3'd3) begin n_fail++; $display("FAIL rgb_geom: got len=%0d lines=%0d want 4/3", line_len, line_cnt); end
  endtask

  task automatic test_raw8;
    mode = 2'd1;
    vpulse;
    setc(5'h14, 6'h29, 5'h14);
    snap;
    repeat (3) ln(4, 8'ha5, 8'ha5);
    vpulse;
    n_tests++; if (n_pix - p0 !== 12) begin n_fail++; $display("FAIL raw_pix: got %0d want 12", n_pix - p0); end
    n_tests++; if (n_badc - c0 !== 0) begin n_fail++; $display("FAIL raw_colour: got %0d bad want 0", n_badc - c0); end
    n_tests++; if (line_len !== 4'd4) begin n_fail++; $display("FAIL raw_len: got %0d want 4", line_len); end
    n_tests++; if (err !== 3'b000 || fcnt !== 16'd2) begin n_fail++; $display("FAIL raw_err_fcnt: got err=%b fcnt=%0d want 000/2", err, fcnt); end
  endtask

  task automatic test_errors;
    ln(3, 8'ha5, 8'ha5);
    n_tests++; if (line_len !== 4'd3) begin n_fail++; $display("FAIL short_len: got %0d want 3", line_len); end
    n_tests++; if (err !== 3'b001) begin n_fail++; $display("FAIL short_err: got %b want 001", err); end
    ln(4, 8'ha5, 8'ha5);
    vpulse;
    n_tests++; if (err !== 3'b011) begin n_fail++; $display("FAIL lines_err: got %b want 011", err); end
    n_tests++; if (line_cnt !== 3'd2 || fcnt !== 16'd3) begin n_fail++; $display("FAIL lines_cnt: got lines=%0d fcnt=%0d want 2/3", line_cnt, fcnt); end
    pulse_clr;
    n_tests++; if (err !== 3'b000) begin n_fail++; $display("FAIL err_clr: got %b want 000", err); end
    repeat (3) ln(4, 8'ha5, 8'ha5);
    vpulse;
    n_tests++; if (err !== 3'b000 || line_cnt !== 3'd3 || fcnt !== 16'd4) begin n_fail++; $display("FAIL clean_frame: got err=%b lines=%0d fcnt=%0d want 000/3/4", err, line_cnt, fcnt); end
  endtask

  task automatic test_odd;
    mode = 2'd0;
    vpulse;
    snap;
    setc(5'h1f, 6'h00, 5'h00);
    ln(7, 8'hf8, 8'h00);
    n_tests++; if (n_pix - p0 !== 3) begin n_fail++; $display("FAIL odd_pix: got %0d want 3", n_pix - p0); end
    n_tests++; if (err !== 3'b101) begin n_fail++; $display("FAIL odd_err: got %b want 101", err); end
    setc(5'h00, 6'h3f, 5'h00);
    ln(8, 8'h07, 8'he0);
    ln(8, 8'h07, 8'he0);
    vpulse;
    n_tests++; if (n_pix - p0 !== 11) begin n_fail++; $display("FAIL odd_total: got %0d want 11", n_pix - p0); end
    n_tests++; if (n_badc - c0 !== 0) begin n_fail++; $display("FAIL odd_repair: got %0d bad want 0", n_badc - c0); end
    n_tests++; if (err !== 3'b101 || line_cnt !== 3'd3 || fcnt !== 16'd5) begin n_fail++; $display("FAIL odd_frame: got err=%b lines=%0d fcnt=%0d want 101/3/5", err, line_cnt, fcnt); end
  endtask

  task automatic test_enable;
    pulse_clr;
    en = 1'b0;
    vpulse;
    snap;
    setc(5'h1f, 6'h00, 5'h00);
    ln(8, 8'hf8, 8'h00);
    en = 1'b1;
    ln(8, 8'hf8, 8'h00);
    ln(8, 8'hf8, 8'h00);
    vpulse;
    n_tests++; if (n_pix - p0 !== 0 || n_eof - f0 !== 0) begin n_fail++; $display("FAIL skip_frame: got pix=%0d eof=%0d want 0/0", n_pix - p0, n_eof - f0); end
    n_tests++; if (fcnt !== 16'd5 || err !== 3'b000) begin n_fail++; $display("FAIL skip_state: got fcnt=%0d err=%b want 5/000", fcnt, err); end
    snap;
    ln(8, 8'hf8, 8'h00);
    mode = 2'd1;
    ln(8, 8'hf8, 8'h00);
    ln(8, 8'hf8, 8'h00);
    mode = 2'd0;
    vpulse;
    n_tests++; if (n_pix - p0 !== 12 || n_badc - c0 !== 0) begin n_fail++; $display("FAIL mode_hold: got pix=%0d bad=%0d want 12/0", n_pix - p0, n_badc - c0); end
    n_tests++; if (fcnt !== 16'd6 || err !== 3'b000 || line_len !== 4'd4) begin n_fail++; $display("FAIL enable_frame: got fcnt=%0d err=%b len=%0d want 6/000/4", fcnt, err, line_len); end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 1'b1, 8'hf8);
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'hf8);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    n_tests++; if (valid !== 1'b0 || synced !== 1'b0) begin n_fail++; $display("FAIL midrst_out: got valid=%b synced=%b want 0/0", valid, synced); end
    n_tests++; if (fcnt !== 16'd0 || err !== 3'b000 || line_len !== 4'd0) begin n_fail++; $display("FAIL midrst_regs: got fcnt=%0d err=%b len=%0d want 0", fcnt, err, line_len); end
    drive(1'b0, 1'b1, 8'hf8);
    rst = 1'b0;
    snap;
    ln(4, 8'h00, 8'hf8);
    ln(8, 8'hf8, 8'h00);
    n_tests++; if (n_pix - p0 !== 0) begin n_fail++; $display("FAIL midrst_unsync: got %0d pixels want 0", n_pix - p0); end
    vpulse;
    ln(8, 8'hf8, 8'h00);
    n_tests++; if (n_pix - p0 !== 4 || synced !== 1'b1) begin n_fail++; $display("FAIL midrst_resync: got pix=%0d synced=%b want 4/1", n_pix - p0, synced); end
  endtask

  initial begin
    setc(5'h00, 6'h00, 5'h00);
    test_reset;
    test_rgb565;
    test_raw8;
    test_errors;
    test_odd;
    test_enable;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
endmodule
